alu_operand_stage: RTL

- Registered ID/EX operand-select stage for the MIPS execution path.
- Selects the ALU B operand from the register value or one of three immediate encodings.
- Resolves EX/MEM and MEM/WB forwarding on both source operands.
- Holds the result under a valid/ready handshake so the downstream ALU can stall the pipeline.

---
 rtl/alu_operand_stage_if.sv | 43 ++++
 rtl/alu_operand_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// Bundled handshake and operand bus for the ID/EX operand-select stage.
// The master side drives operands and forwarding sources; the slave is the stage itself.
interface alu_operand_stage_if #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic [IMM_W-1:0]  imm;
    logic [1:0]        alu_src;
    logic              exmem_we;
    logic [REG_AW-1:0] exmem_rd;
    logic [WIDTH-1:0]  exmem_result;
    logic              memwb_we;
    logic [REG_AW-1:0] memwb_rd;
    logic [WIDTH-1:0]  memwb_result;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  store_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, rs_addr, rt_addr, rs_data, rt_data, imm, alu_src,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        input  in_ready, out_valid, op_a, op_b, store_data, stall_cnt
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, rs_data, rt_data, imm, alu_src,
               exmem_we, exmem_rd, exmem_result, memwb_we, memwb_rd, memwb_result,
               out_ready,
        output in_ready, out_valid, op_a, op_b, store_data, stall_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ID/EX operand select with optional EX/MEM and MEM/WB forwarding.
// Define ALU_OPERAND_FORWARD_EN to compile the forwarding paths; otherwise register-file data is used.
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    alu_operand_stage_if.slave bus
);
    // Handshake: a beat transfers on a rising edge where valid && ready.
    // The input side is ready whenever the output register is empty or being drained.
    logic              accept;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [WIDTH-1:0]  rs_fwd;
    logic [WIDTH-1:0]  rt_fwd;
    logic [WIDTH-1:0]  imm_sext;
    logic [WIDTH-1:0]  imm_zext;
    logic [WIDTH-1:0]  imm_lui;
    logic [WIDTH-1:0]  op_b_sel;

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  store_data_q, store_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    assign rs_addr      = bus.rs_addr;
    assign rt_addr      = bus.rt_addr;
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    generate
        if (IMM_W == WIDTH) begin : g_full_imm
            assign imm_sext = bus.imm;
            assign imm_lui  = bus.imm;
        end else begin : g_ext_imm
            assign imm_sext = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
            assign imm_lui  = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
        end
    endgenerate
    assign imm_zext = WIDTH'(bus.imm);

`ifdef ALU_OPERAND_FORWARD_EN
    // EX/MEM is the younger producer, so it is checked first; r0 is hardwired zero.
    always_comb begin
        rs_fwd = bus.rs_data;
        rt_fwd = bus.rt_data;
        if (bus.exmem_we && bus.exmem_rd == rs_addr && rs_addr != '0) begin
            rs_fwd = bus.exmem_result;
        end else if (bus.memwb_we && bus.memwb_rd == rs_addr && rs_addr != '0) begin
            rs_fwd = bus.memwb_result;
        end
        if (bus.exmem_we && bus.exmem_rd == rt_addr && rt_addr != '0) begin
            rt_fwd = bus.exmem_result;
        end else if (bus.memwb_we && bus.memwb_rd == rt_addr && rt_addr != '0) begin
            rt_fwd = bus.memwb_result;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs_addr, rt_addr, bus.exmem_we, bus.exmem_rd, bus.exmem_result,
                                 bus.memwb_we, bus.memwb_rd, bus.memwb_result};
    assign rs_fwd = bus.rs_data;
    assign rt_fwd = bus.rt_data;
`endif

    always_comb begin
        op_b_sel = rt_fwd;
        case (bus.alu_src)
            2'd0:    op_b_sel = rt_fwd;
            2'd1:    op_b_sel = imm_sext;
            2'd2:    op_b_sel = imm_zext;
            default: op_b_sel = imm_lui;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        store_data_d = store_data_q;
        stall_cnt_d  = stall_cnt_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            op_a_d       = rs_fwd;
            op_b_d       = op_b_sel;
            store_data_d = rt_fwd;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && !bus.out_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            store_data_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            store_data_q <= store_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.op_a       = op_a_q;
    assign bus.op_b       = op_b_q;
    assign bus.store_data = store_data_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule
